// File: rtl/fetch_prefetch_ctrl_pkg.sv
// Shared types for the instruction-fetch path: FSM state encoding, queued
// fetch entry layout and the fetch-target legality rule.
package core_pkg;

    localparam int XLEN = 32;

    typedef enum logic [0:0] {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // A fetch target is usable only when word aligned and inside the ROM.
    function automatic logic pc_legal(input logic [XLEN-1:0] pc,
                                      input logic [XLEN-1:0] limit);
        return (pc[1:0] == 2'b00) && (pc < limit);
    endfunction

endpackage

// File: rtl/fetch_prefetch_ctrl_if.sv
// Bus bundle between the fetch controller, the instruction ROM, the
// branch/redirect logic and the decode stage.
interface fetch_prefetch_ctrl_if;
    import core_pkg::*;

    logic [XLEN-1:0] imem_pc;
    logic [XLEN-1:0] imem_instr;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_ready;
    logic            fetch_fault;
    logic [XLEN-1:0] fault_pc;

    modport master (
        output imem_pc,
        input  imem_instr,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        output instr,
        output instr_pc,
        input  instr_ready,
        output fetch_fault,
        output fault_pc
    );

    modport slave (
        input  imem_pc,
        output imem_instr,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output instr_ready,
        input  fetch_fault,
        input  fault_pc
    );

endinterface

// File: rtl/fetch_prefetch_ctrl_prefetch_fifo.sv
// Synchronous FIFO of fetched (pc, instr) entries with a single-cycle flush.
// The head entry is read straight from registered slots.
module prefetch_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  fetch_entry_t               wr_data_i,
    output fetch_entry_t               rd_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_w;
    logic             do_pop_w;
    logic             do_push_w;
    fetch_entry_t     slots_w [DEPTH];

    assign full_w    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign do_pop_w  = pop_i && !empty_o && !flush_i;
    // A full FIFO may still accept an entry when the head leaves in the same cycle.
    assign do_push_w = push_i && (!full_w || do_pop_w) && !flush_i;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            fetch_entry_t slot_q;
            always_ff @(posedge clk) begin
                if (do_push_w && (wr_ptr_q == PTR_W'(gi))) begin
                    slot_q <= wr_data_i;
                end
            end
            assign slots_w[gi] = slot_q;
        end
    endgenerate

    // Stale slot contents are masked so an empty FIFO presents all zeros.
    assign rd_data_o = empty_o ? '0 : slots_w[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_w) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_w) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push_w, do_pop_w})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_prefetch_ctrl.sv
// Instruction fetch sequencer: walks the combinational ROM, queues returned
// words for decode, flushes on redirect and halts on an unusable fetch PC.
module fetch_prefetch_ctrl
    import core_pkg::*;
#(
    parameter int              DEPTH     = 4,
    parameter int              MEM_WORDS = 512,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    fetch_prefetch_ctrl_if.master fetch_if
);

    localparam int              CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [0:0]      RUN      = FS_RUN;
    localparam logic [0:0]      HALT     = FS_HALT;
    localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(MEM_WORDS * 4);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [0:0]      state_q, state_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] fault_pc_q, fault_pc_d;

    logic            redirect_w;
    logic            pc_ok_w;
    logic            push_w;
    logic            pop_w;
    logic            room_w;
    fetch_entry_t    push_entry_w;
    fetch_entry_t    head_w;
    logic [CNT_W-1:0] fifo_count_w;
    logic            fifo_empty_w;

    assign redirect_w = fetch_if.redirect_valid;
    assign pc_ok_w    = pc_legal(fetch_pc_q, PC_LIMIT);

    // A redirect cancels both the pop and the push of its cycle.
    assign pop_w  = !fifo_empty_w && fetch_if.instr_ready && !redirect_w;
    assign room_w = (fifo_count_w < CNT_W'(DEPTH)) || pop_w;
    assign push_w = (state_q == RUN) && pc_ok_w && room_w && !redirect_w;

    assign push_entry_w.pc    = fetch_pc_q;
    assign push_entry_w.instr = fetch_if.imem_instr;

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (push_w),
        .pop_i     (pop_w),
        .flush_i   (redirect_w),
        .wr_data_i (push_entry_w),
        .rd_data_o (head_w),
        .count_o   (fifo_count_w),
        .empty_o   (fifo_empty_w)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        state_d    = state_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        if (redirect_w) begin
            fetch_pc_d = fetch_if.redirect_pc;
            state_d    = RUN;
            fault_d    = 1'b0;
            fault_pc_d = '0;
        end else if ((state_q == RUN) && !pc_ok_w) begin
            state_d    = HALT;
            fault_d    = 1'b1;
            fault_pc_d = fetch_pc_q;
        end else if (push_w) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            state_q    <= RUN;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            state_q    <= state_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    assign fetch_if.imem_pc     = fetch_pc_q;
    assign fetch_if.instr_valid = !fifo_empty_w;
    assign fetch_if.instr       = head_w.instr;
    assign fetch_if.instr_pc    = head_w.pc;
    assign fetch_if.fetch_fault = fault_q;
    assign fetch_if.fault_pc    = fault_pc_q;

endmodule
